// File: rtl/ntt_ctrl_pkg.sv
// Shared types and constants for NTT job sequencing: controller state, job geometry, error codes.
package ntt_ctrl_pkg;

    localparam int unsigned LOG_N      = 12;
    localparam int unsigned LOAD_WORDS = 2048;
    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned WORD_CNT_W = 12;
    localparam int unsigned DATA_W     = 60;
    localparam int unsigned TIMER_W    = 16;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BEATS   = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StStart,
        StWaitBusy,
        StRun
    } ctrl_state_e;

    // Result beats per job: N/4 words spread over the processor's cores.
    function automatic int unsigned out_beats(input int unsigned log_core_count);
        return 1 << (LOG_N - 2 - log_core_count);
    endfunction

endpackage

// File: rtl/ntt_timeout_counter.sv
// Saturating up-counter that flags when Limit cycles have elapsed since the last load.
module ntt_timeout_counter #(
    parameter int unsigned Width = 16,
    parameter int unsigned Limit = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q >= Width'(Limit));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ntt_job_controller.sv
// Sequences one NTT job on a single processor: streams coefficient words in, pulses start,
// then frames the result window with beat index, done and error.
module ntt_job_controller
    import ntt_ctrl_pkg::*;
#(
    parameter int unsigned LOG_CORE_COUNT = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    localparam int unsigned OUT_BEATS = out_beats(LOG_CORE_COUNT),
    localparam int unsigned BEAT_W = $clog2(OUT_BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              proc_write_enable_o,
    output logic [ADDR_W-1:0] proc_address_in_o,
    output logic [DATA_W-1:0] proc_data_in_o,
    output logic              proc_start_o,
    input  logic              proc_ready_i,
    input  logic              proc_output_active_i,
    output logic              beat_valid_o,
    output logic [BEAT_W-1:0] beat_index_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        error_o
);

    localparam logic [WORD_CNT_W-1:0] LAST_WORD  = WORD_CNT_W'(LOAD_WORDS - 1);
    localparam logic [BEAT_W:0]       BEATS_FULL = (BEAT_W + 1)'(OUT_BEATS);

    ctrl_state_e           state_q, state_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  start_q, start_d;
    logic                  beat_valid_q, beat_valid_d;
    logic [BEAT_W:0]       beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0]     beat_index_q, beat_index_d;
    logic                  seen_act_q, seen_act_d;
    logic                  done_q, done_d;
    logic [1:0]            error_q, error_d;

    logic s_ready;
    logic hs;
    logic timer_load;
    logic timer_en;
    logic timer_expired;
    logic timeout;
    logic fall;

    assign hs      = s_valid_i & s_ready;
    assign timeout = timer_expired & ~seen_act_q & ~proc_output_active_i;
    assign fall    = beat_valid_q & ~proc_output_active_i;

    // Timer measures start-to-first-output; stops once output_active has been seen.
    assign timer_load = (state_q == StStart) | abort_i;
    assign timer_en   = ((state_q == StWaitBusy) | (state_q == StRun)) & ~seen_act_q;

    ntt_timeout_counter #(
        .Width(TIMER_W),
        .Limit(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (timer_load),
        .enable_i (timer_en),
        .expired_o(timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            word_cnt_q   <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            start_q      <= 1'b0;
            beat_valid_q <= 1'b0;
            beat_cnt_q   <= '0;
            beat_index_q <= '0;
            seen_act_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            start_q      <= start_d;
            beat_valid_q <= beat_valid_d;
            beat_cnt_q   <= beat_cnt_d;
            beat_index_q <= beat_index_d;
            seen_act_q   <= seen_act_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (hs) state_d = StLoad;
            StLoad:     if (hs && word_cnt_q == LAST_WORD) state_d = StFlush;
            StFlush:    state_d = StStart;
            StStart:    if (proc_ready_i) state_d = StWaitBusy;
            StWaitBusy: begin
                if (timeout) state_d = StIdle;
                else if (!proc_ready_i) state_d = StRun;
            end
            StRun:      if (timeout || fall) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        if (abort_i) state_d = StIdle;
    end

    always_comb begin
        unique case (state_q)
            StIdle:  s_ready = proc_ready_i;
            StLoad:  s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
        if (abort_i) s_ready = 1'b0;

        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        word_cnt_d   = word_cnt_q;
        start_d      = 1'b0;
        beat_valid_d = 1'b0;
        beat_cnt_d   = beat_cnt_q;
        beat_index_d = beat_index_q;
        seen_act_d   = seen_act_q;
        done_d       = 1'b0;
        error_d      = error_q;

        if (hs) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            data_d     = s_data_i;
            word_cnt_d = word_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle:  if (hs) error_d = ERR_NONE;
            StStart: start_d = proc_ready_i;
            StWaitBusy: begin
                if (proc_output_active_i) seen_act_d = 1'b1;
                else if (timeout) error_d = ERR_TIMEOUT;
            end
            StRun: begin
                if (proc_output_active_i) begin
                    seen_act_d   = 1'b1;
                    beat_valid_d = 1'b1;
                    if (beat_cnt_q == BEATS_FULL) begin
                        error_d = ERR_BEATS;
                    end else begin
                        beat_index_d = beat_cnt_q[BEAT_W-1:0];
                        beat_cnt_d   = beat_cnt_q + 1'b1;
                    end
                end else if (beat_valid_q) begin
                    // An earlier overrun already flagged the job, so a full count is not enough.
                    if (beat_cnt_q == BEATS_FULL && error_q == ERR_NONE) done_d = 1'b1;
                    else error_d = ERR_BEATS;
                end else if (timeout) begin
                    error_d = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase

        if (state_d == StIdle) begin
            word_cnt_d   = '0;
            beat_cnt_d   = '0;
            beat_index_d = '0;
            seen_act_d   = 1'b0;
        end

        if (abort_i) begin
            start_d      = 1'b0;
            beat_valid_d = 1'b0;
            done_d       = 1'b0;
            error_d      = error_q;
        end
    end

    assign s_ready_o           = s_ready;
    assign proc_write_enable_o = we_q;
    assign proc_address_in_o   = addr_q;
    assign proc_data_in_o      = data_q;
    assign proc_start_o        = start_q;
    assign beat_valid_o        = beat_valid_q;
    assign beat_index_o        = beat_index_q;
    assign busy_o              = (state_q != StIdle);
    assign done_o              = done_q;
    assign error_o             = error_q;

endmodule

// File: tb/tb_ntt_job_controller.sv
// Bench for ntt_job_controller: random load streams and a behavioural processor model.
module tb_ntt_job_controller;

    localparam int NWORDS = 2048;
    localparam int NBEATS = 1 << (10 - 4);
    localparam int TMO    = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort;
    logic        s_valid;
    logic        s_ready;
    logic [59:0] s_data;
    logic        we;
    logic [10:0] addr;
    logic [59:0] data;
    logic        start;
    logic        proc_ready;
    logic        proc_active;
    logic        beat_valid;
    logic [5:0]  beat_index;
    logic        busy;
    logic        done;
    logic [1:0]  error;

    always #5 clk = ~clk;

    ntt_job_controller #(
        .LOG_CORE_COUNT(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .abort_i             (abort),
        .s_valid_i           (s_valid),
        .s_ready_o           (s_ready),
        .s_data_i            (s_data),
        .proc_write_enable_o (we),
        .proc_address_in_o   (addr),
        .proc_data_in_o      (data),
        .proc_start_o        (start),
        .proc_ready_i        (proc_ready),
        .proc_output_active_i(proc_active),
        .beat_valid_o        (beat_valid),
        .beat_index_o        (beat_index),
        .busy_o              (busy),
        .done_o              (done),
        .error_o             (error)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int done_cnt = 0;
    int hs_cyc[$];
    int obs_we_cyc[$];
    int obs_addr[$];
    int start_cyc[$];
    int obs_beat[$];
    logic [59:0] exp_words[$];
    logic [59:0] obs_data[$];

    task automatic clear_capture();
        hs_cyc.delete();
        obs_we_cyc.delete();
        obs_addr.delete();
        start_cyc.delete();
        obs_beat.delete();
        exp_words.delete();
        obs_data.delete();
        done_cnt = 0;
    endtask

    // One clock, then record whatever the DUT presents to the processor and the sink.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (we === 1'b1) begin
            obs_we_cyc.push_back(cyc);
            obs_addr.push_back(int'(addr));
            obs_data.push_back(data);
        end
        if (start === 1'b1) start_cyc.push_back(cyc);
        if (beat_valid === 1'b1) obs_beat.push_back(int'(beat_index));
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic drive_load(input int gap_pct, input int n_words);
        int acc;
        int guard;
        logic [63:0] r;
        acc = 0;
        guard = 0;
        while (acc < n_words && guard < 20000) begin
            s_valid = ($urandom_range(99) >= gap_pct);
            r = {$urandom, $urandom};
            s_data = r[59:0];
            #1;
            if (s_valid && s_ready) begin
                hs_cyc.push_back(cyc + 1);
                exp_words.push_back(s_data);
                acc++;
            end
            step();
            guard++;
        end
        s_valid = 1'b0;
    endtask

    // Processor model: drops ready after start, emits n_beats of output_active, then recovers.
    task automatic proc_job(input int n_beats, input int stop_after, input bit hold_low,
                            output int t_start, output int t_idle);
        int guard;
        t_start = -1;
        t_idle = -1;
        guard = 0;
        while (start_cyc.size() == 0 && guard < 50) begin
            step();
            guard++;
        end
        if (start_cyc.size() == 0) return;
        t_start = start_cyc[0];
        step();
        step();
        proc_ready = 1'b0;
        if (hold_low) begin
            guard = 0;
            while (busy && guard < 70000) begin
                step();
                guard++;
            end
            if (!busy) t_idle = cyc;
            return;
        end
        repeat ($urandom_range(2, 8)) step();
        proc_active = 1'b1;
        for (int i = 0; i < n_beats; i++) begin
            if (i == stop_after) return;
            step();
        end
        proc_active = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin
            step();
            guard++;
        end
        if (!busy) t_idle = cyc;
        repeat (3) step();
        proc_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        abort = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        proc_ready = 1'b0;
        proc_active = 1'b0;
        #1;
        tests_run++;
        if ({we, start, s_ready, beat_valid, busy, done} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000000", {we, start, s_ready, beat_valid, busy, done});
        end
        tests_run++;
        if ({addr, data, beat_index, error} !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: got addr=%0h data=%0h idx=%0d err=%b expected all 0",
                     addr, data, beat_index, error);
        end
        step();
        step();
        rst_n = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (s_ready !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_gated: got s_ready=%b busy=%b expected 0 0", s_ready, busy);
            end
            step();
        end
        s_valid = 1'b0;
        proc_ready = 1'b1;
        #1;
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_ready: got s_ready=%b expected 1", s_ready);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int ts, ti, h0, st, n;
        clear_capture();
        drive_load(0, NWORDS);
        proc_job(NBEATS, -1, 1'b0, ts, ti);
        h0 = (hs_cyc.size() > 0) ? hs_cyc[0] : -1;
        tests_run++;
        if (obs_we_cyc.size() != NWORDS || exp_words.size() != NWORDS) begin
            tests_failed++;
            $display("FAIL b2b_write_count: got %0d writes / %0d accepted expected %0d",
                     obs_we_cyc.size(), exp_words.size(), NWORDS);
        end
        n = (obs_we_cyc.size() < exp_words.size()) ? obs_we_cyc.size() : exp_words.size();
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (obs_addr[i] != i || obs_data[i] !== exp_words[i] || obs_we_cyc[i] != h0 + i) begin
                tests_failed++;
                $display("FAIL b2b_write[%0d]: got addr=%0d cyc=%0d expected addr=%0d cyc=%0d",
                         i, obs_addr[i], obs_we_cyc[i], i, h0 + i);
            end
        end
        st = (start_cyc.size() > 0) ? start_cyc[0] : -1;
        tests_run++;
        if (start_cyc.size() != 1 || st != h0 + NWORDS + 1) begin
            tests_failed++;
            $display("FAIL b2b_start: got %0d pulses first at +%0d expected 1 at +%0d",
                     start_cyc.size(), st - h0, NWORDS + 1);
        end
        tests_run++;
        if (obs_beat.size() != NBEATS) begin
            tests_failed++;
            $display("FAIL b2b_beats: got %0d expected %0d", obs_beat.size(), NBEATS);
        end
        for (int i = 0; i < obs_beat.size() && i < NBEATS; i++) begin
            tests_run++;
            if (obs_beat[i] != i) begin
                tests_failed++;
                $display("FAIL b2b_index[%0d]: got %0d expected %0d", i, obs_beat[i], i);
            end
        end
        tests_run++;
        if (done_cnt != 1 || error !== 2'b00 || ti < 0) begin
            tests_failed++;
            $display("FAIL b2b_done: got done=%0d err=%b idle_at=%0d expected 1 00 >=0",
                     done_cnt, error, ti);
        end
    endtask

    task automatic test_load_gaps();
        int ts, ti, n;
        clear_capture();
        drive_load(40, NWORDS);
        proc_job(NBEATS - 1, -1, 1'b0, ts, ti);
        tests_run++;
        if (obs_we_cyc.size() != exp_words.size() || exp_words.size() != NWORDS) begin
            tests_failed++;
            $display("FAIL gap_write_count: got %0d writes / %0d accepted expected %0d",
                     obs_we_cyc.size(), exp_words.size(), NWORDS);
        end
        n = (obs_we_cyc.size() < exp_words.size()) ? obs_we_cyc.size() : exp_words.size();
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (obs_addr[i] != i || obs_data[i] !== exp_words[i] || obs_we_cyc[i] != hs_cyc[i]) begin
                tests_failed++;
                $display("FAIL gap_write[%0d]: got addr=%0d cyc=%0d expected addr=%0d cyc=%0d",
                         i, obs_addr[i], obs_we_cyc[i], i, hs_cyc[i]);
            end
        end
        tests_run++;
        if (obs_beat.size() != NBEATS - 1 || done_cnt != 0 || error !== 2'b10) begin
            tests_failed++;
            $display("FAIL short_job: got beats=%0d done=%0d err=%b expected %0d 0 10",
                     obs_beat.size(), done_cnt, error, NBEATS - 1);
        end
    endtask

    task automatic test_overrun();
        int ts, ti, exp_idx;
        clear_capture();
        drive_load(10, NWORDS);
        tests_run++;
        if (error !== 2'b00) begin
            tests_failed++;
            $display("FAIL error_cleared: got %b expected 00", error);
        end
        proc_job(NBEATS + 1, -1, 1'b0, ts, ti);
        tests_run++;
        if (obs_beat.size() != NBEATS + 1) begin
            tests_failed++;
            $display("FAIL over_beats: got %0d expected %0d", obs_beat.size(), NBEATS + 1);
        end
        for (int i = 0; i < obs_beat.size(); i++) begin
            exp_idx = (i < NBEATS) ? i : NBEATS - 1;
            tests_run++;
            if (obs_beat[i] != exp_idx) begin
                tests_failed++;
                $display("FAIL over_index[%0d]: got %0d expected %0d", i, obs_beat[i], exp_idx);
            end
        end
        tests_run++;
        if (done_cnt != 0 || error !== 2'b10 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL over_result: got done=%0d err=%b busy=%b expected 0 10 0",
                     done_cnt, error, busy);
        end
    endtask

    task automatic test_timeout();
        int ts, ti;
        clear_capture();
        drive_load(0, NWORDS);
        proc_job(0, -1, 1'b1, ts, ti);
        tests_run++;
        if (ts < 0 || ti - ts < TMO - 1 || ti - ts > TMO + 3) begin
            tests_failed++;
            $display("FAIL timeout_delay: got %0d cycles expected about %0d", ti - ts, TMO);
        end
        tests_run++;
        if (error !== 2'b01 || busy !== 1'b0 || done_cnt != 0) begin
            tests_failed++;
            $display("FAIL timeout_result: got err=%b busy=%b done=%0d expected 01 0 0",
                     error, busy, done_cnt);
        end
        clear_capture();
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (s_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_gate: got s_ready=%b expected 0", s_ready);
            end
            step();
        end
        tests_run++;
        if (obs_we_cyc.size() != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_no_accept: got writes=%0d busy=%b expected 0 0",
                     obs_we_cyc.size(), busy);
        end
        proc_ready = 1'b1;
        #1;
        step();
        s_valid = 1'b0;
        tests_run++;
        if (error !== 2'b00 || busy !== 1'b1 || we !== 1'b1 || addr !== 11'd0) begin
            tests_failed++;
            $display("FAIL timeout_recover: got err=%b busy=%b we=%b addr=%0d expected 00 1 1 0",
                     error, busy, we, addr);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_reset_abort();
        int ts, ti;
        clear_capture();
        drive_load(0, 1000);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({we, start, beat_valid, busy, done} !== 5'b0 || addr !== '0 || data !== '0 || error !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset: got we=%b busy=%b addr=%0d err=%b expected all 0",
                     we, busy, addr, error);
        end
        step();
        step();
        rst_n = 1'b1;
        clear_capture();
        drive_load(0, NWORDS);
        tests_run++;
        if (obs_addr.size() != NWORDS || obs_addr[0] != 0 || obs_addr[NWORDS-1] != NWORDS - 1) begin
            tests_failed++;
            $display("FAIL reload_addr: got %0d writes expected %0d from 0", obs_addr.size(), NWORDS);
        end
        proc_job(NBEATS, 10, 1'b0, ts, ti);
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || beat_valid !== 1'b0 || we !== 1'b0 || error !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_run: got busy=%b bv=%b we=%b err=%b expected 0 0 0 00",
                     busy, beat_valid, we, error);
        end
        tests_run++;
        if (obs_beat.size() < 9 || obs_beat.size() > 11 || done_cnt != 0) begin
            tests_failed++;
            $display("FAIL abort_beats: got beats=%0d done=%0d expected ~10 0", obs_beat.size(), done_cnt);
        end
        clear_capture();
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (s_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort_gate: got s_ready=%b expected 0", s_ready);
            end
            step();
        end
        s_valid = 1'b0;
        tests_run++;
        if (obs_beat.size() != 0 || obs_we_cyc.size() != 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: got beats=%0d writes=%0d expected 0 0",
                     obs_beat.size(), obs_we_cyc.size());
        end
        proc_active = 1'b0;
        proc_ready = 1'b1;
        step();
        clear_capture();
        drive_load(0, 5);
        tests_run++;
        if (obs_addr.size() != 5 || obs_addr[0] != 0 || obs_addr[4] != 4) begin
            tests_failed++;
            $display("FAIL fresh_addr: got %0d writes expected 5 from 0", obs_addr.size());
        end
        abort = 1'b1;
        s_valid = 1'b1;
        #1;
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_prio: got s_ready=%b expected 0", s_ready);
        end
        step();
        abort = 1'b0;
        s_valid = 1'b0;
        tests_run++;
        if (we !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_load: got we=%b busy=%b expected 0 0", we, busy);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_gaps();
        test_overrun();
        test_timeout();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
